// File: rtl/sap1_controller_sequencer.sv
// SAP-1 control unit: six-state ring counter (T1..T6) plus a HALTED state,
// decoding the IR opcode into the load/enable strobes of every W-bus register.
module sap1_controller_sequencer #(
  parameter logic [3:0] OP_LDA = 4'b0000,
  parameter logic [3:0] OP_ADD = 4'b0001,
  parameter logic [3:0] OP_SUB = 4'b0010,
  parameter logic [3:0] OP_OUT = 4'b1110,
  parameter logic [3:0] OP_HLT = 4'b1111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  output logic       pc_increment,
  output logic       pc_enable,
  output logic       mar_load_n,
  output logic       ram_enable_n,
  output logic       ir_load_n,
  output logic       ir_enable_n,
  output logic       a_load_n,
  output logic       a_enable,
  output logic       alu_subtract,
  output logic       alu_enable,
  output logic       b_load_n,
  output logic       out_load_n,
  output logic       halt,
  output logic [5:0] t_state
);

  typedef enum logic [2:0] {
    T1, T2, T3, T4, T5, T6, HALTED
  } state_t;

  state_t state;
  state_t next_state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= T1;
    else        state <= next_state;
  end

  always_comb begin
    next_state   = state;
    pc_increment = 1'b0;
    pc_enable    = 1'b0;
    mar_load_n   = 1'b1;
    ram_enable_n = 1'b1;
    ir_load_n    = 1'b1;
    ir_enable_n  = 1'b1;
    a_load_n     = 1'b1;
    a_enable     = 1'b0;
    alu_subtract = 1'b0;
    alu_enable   = 1'b0;
    b_load_n     = 1'b1;
    out_load_n   = 1'b1;
    halt         = 1'b0;
    t_state      = 6'b000000;

    case (state)
      T1: begin
        next_state = T2;
        t_state    = 6'b000001;
        pc_enable  = 1'b1;
        mar_load_n = 1'b0;
      end
      T2: begin
        next_state   = T3;
        t_state      = 6'b000010;
        pc_increment = 1'b1;
      end
      T3: begin
        next_state   = T4;
        t_state      = 6'b000100;
        ram_enable_n = 1'b0;
        ir_load_n    = 1'b0;
      end
      T4: begin
        next_state = (opcode == OP_HLT) ? HALTED : T5;
        t_state    = 6'b001000;
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB: begin
            ir_enable_n = 1'b0;
            mar_load_n  = 1'b0;
          end
          OP_OUT: begin
            a_enable   = 1'b1;
            out_load_n = 1'b0;
          end
          default: ;
        endcase
      end
      T5: begin
        next_state = T6;
        t_state    = 6'b010000;
        case (opcode)
          OP_LDA: begin
            ram_enable_n = 1'b0;
            a_load_n     = 1'b0;
          end
          OP_ADD, OP_SUB: begin
            ram_enable_n = 1'b0;
            b_load_n     = 1'b0;
          end
          default: ;
        endcase
      end
      T6: begin
        next_state = T1;
        t_state    = 6'b100000;
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          alu_enable   = 1'b1;
          a_load_n     = 1'b0;
          alu_subtract = (opcode == OP_SUB);
        end
      end
      HALTED: begin
        halt = 1'b1;
      end
      default: next_state = T1;
    endcase

    // While reset is held even the T1 word is suppressed so no strobe leaks out.
    if (!reset) begin
      next_state   = T1;
      pc_increment = 1'b0;
      pc_enable    = 1'b0;
      mar_load_n   = 1'b1;
      ram_enable_n = 1'b1;
      ir_load_n    = 1'b1;
      ir_enable_n  = 1'b1;
      a_load_n     = 1'b1;
      a_enable     = 1'b0;
      alu_subtract = 1'b0;
      alu_enable   = 1'b0;
      b_load_n     = 1'b1;
      out_load_n   = 1'b1;
      halt         = 1'b0;
      t_state      = 6'b000001;
    end
  end

endmodule

// File: doc/sap1_controller_sequencer.md
Name: sap1_controller_sequencer

Overview:
- Control unit of the SAP-1 datapath. It drives the load and enable strobes that every bus register obeys, including the accumulator's active-low load and active-high bus enable.
- A six-state ring counter (T1..T6) sequences fetch and execute. It decodes the 4-bit opcode from the instruction register.
- It is the initiator of every W-bus transfer; registers on the bus are responders.

Parameters:
- OP_LDA, 4'b0000, load accumulator from RAM[operand]
- OP_ADD, 4'b0001, A <= A + RAM[operand]
- OP_SUB, 4'b0010, A <= A - RAM[operand]
- OP_OUT, 4'b1110, output register <= A
- OP_HLT, 4'b1111, stop sequencing

Ports:
- clk  input  1  system clock, all state changes on posedge
- reset  input  1  asynchronous, active-low reset
- opcode  input  4  IR upper nibble; stable from T4 onward
- pc_increment  output  1  Cp, active-high: PC increments at next posedge
- pc_enable  output  1  Ep, active-high: PC drives W bus
- mar_load_n  output  1  ~Lm, active-low MAR load
- ram_enable_n  output  1  ~CE, active-low: RAM drives W bus
- ir_load_n  output  1  ~Li, active-low IR load
- ir_enable_n  output  1  ~Ei, active-low: IR operand nibble drives W bus
- a_load_n  output  1  ~La, active-low accumulator load
- a_enable  output  1  Ea, active-high: accumulator drives W bus
- alu_subtract  output  1  Su, high selects subtract
- alu_enable  output  1  Eu, active-high: ALU drives W bus
- b_load_n  output  1  ~Lb, active-low B register load
- out_load_n  output  1  ~Lo, active-low output register load
- halt  output  1  high once HLT has executed
- t_state  output  6  one-hot ring state, bit0=T1 .. bit5=T6

Behaviour:
- Ring counter states: T1..T6 (one-hot) plus HALTED.
- Each posedge advances T(n) to T(n+1). T6 advances to T1.
- HALTED is absorbing; only reset leaves it.
- Control outputs are combinational from the current state and opcode. They are valid for the whole state, and targets act on the posedge that ends the state.
- Inactive levels: active-high strobes 0, active-low strobes 1.
- Reset asserted (reset=0), taking effect immediately and asynchronously:
  - state=T1, t_state=6'b000001, halt=0.
  - All control outputs forced inactive while reset is low, including the T1 word.
- After reset deasserts: T1 word appears combinationally; the first posedge moves to T2.
- Fetch, all opcodes:
  - T1: pc_enable=1, mar_load_n=0.
  - T2: pc_increment=1.
  - T3: ram_enable_n=0, ir_load_n=0.
- LDA:
  - T4: ir_enable_n=0, mar_load_n=0.
  - T5: ram_enable_n=0, a_load_n=0.
  - T6: idle.
- ADD:
  - T4: ir_enable_n=0, mar_load_n=0.
  - T5: ram_enable_n=0, b_load_n=0.
  - T6: alu_enable=1, a_load_n=0, alu_subtract=0.
- SUB: as ADD, but alu_subtract=1 in T6 only.
- OUT:
  - T4: a_enable=1, out_load_n=0.
  - T5, T6: idle.
- HLT:
  - T4: all control outputs inactive. The posedge ending T4 enters HALTED.
  - In HALTED: halt=1, t_state=0, all control outputs inactive, clock ignored.
- Undefined opcodes: T4..T6 idle (NOP). The sequence returns to T1 normally.
- Every instruction occupies exactly 6 clocks except HLT, which halts after 4.
- At most one bus driver is active per state: pc_enable, ~ram_enable_n, ~ir_enable_n, a_enable, alu_enable are mutually exclusive. The bench must assert this every cycle.
- opcode is ignored in T1..T3. Changes to opcode during T1..T3 have no effect.
- Reset mid-instruction, in any state including HALTED:
  - Immediate return to T1, outputs inactive.
  - No partial strobe is held.

Test Plan:
- Reset held low 3 clocks, then released -> during reset all strobes inactive, t_state=000001, halt=0. After release, pc_enable=1 and mar_load_n=0 before the first posedge. After 1 posedge, t_state=000010 and pc_increment=1.
- opcode=4'b0000 (LDA), run 6 clocks from T1 -> T4: ir_enable_n=0, mar_load_n=0. T5: ram_enable_n=0, a_load_n=0. T6: all inactive. Then back to T1.
- opcode=4'b0010 (SUB) -> T5: b_load_n=0. T6: alu_enable=1, a_load_n=0, alu_subtract=1. Repeat with 4'b0001 (ADD) -> identical except alu_subtract=0.
- opcode=4'b1110 (OUT) then 4'b0101 (undefined) -> OUT: a_enable=1 and out_load_n=0 in T4 only. Undefined: T4..T6 all inactive. Both return to T1 after 6 clocks. The bus-driver one-hot check passes every cycle.
- opcode=4'b1111 (HLT) -> after the T4 posedge, halt=1, t_state=0, all strobes inactive for 20+ clocks. Then reset low -> halt=0 and t_state=000001 without waiting for a clock edge.
- Reset asserted asynchronously mid-T5 of ADD (between clock edges) -> b_load_n returns to 1 immediately and t_state=000001. After release, fetch restarts at T1.
